// File: rtl/stripe_sched_if.sv
// Byte-stream and lane-word bundle between the TX mux, the stripe scheduler and the lane serializers.
// Latency: none, wiring only.
// Backpressure: the scheduler drives in_ready; the lane side has no backpressure, and out_valid is a strobe.
// Ports: in_valid/in_data/in_sop/in_eop/in_tlp and in_ready carry the upstream byte stream;
//        TL0..TL3/out_valid/abort carry the registered lane word.
interface stripe_sched_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sop;
    logic       in_eop;
    logic       in_tlp;
    logic       in_ready;
    logic [7:0] TL0;
    logic [7:0] TL1;
    logic [7:0] TL2;
    logic [7:0] TL3;
    logic       out_valid;
    logic       abort;

    // TX mux / environment side
    modport master (
        output in_valid, in_data, in_sop, in_eop, in_tlp,
        input  in_ready, TL0, TL1, TL2, TL3, out_valid, abort
    );

    // Scheduler side
    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_tlp,
        output in_ready, TL0, TL1, TL2, TL3, out_valid, abort
    );
endinterface

// File: rtl/stripe_sched.sv
// 4-lane transmit scheduler: stripes upstream bytes onto TL0..TL3 and adds STP/SDP, END, EDB, PAD, IDL and COM+SKP framing.
// Latency: one symbol slot per clk; a symbol written in slot k reaches TLk at the next slot-3 edge, and out_valid follows for one cycle.
// Backpressure: in_ready is high only while a packet body streams (decoded from state); a missing byte then aborts the packet with EDB.
// Ports: clk, reset_L (async active low); bus.slave carries the upstream byte handshake (in_*), the lane word
//        TL0..TL3 with its out_valid strobe, and an abort pulse that marks EDB insertion.
module stripe_sched #(
    parameter int SKP_INTERVAL = 64    // words between SKP ordered-set requests, 2..1023
) (
    input  logic          clk,
    input  logic          reset_L,
    stripe_sched_if.slave bus
);

    // Symbol encodings; these must agree with the unstriping side.
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_EDB = 8'hFE;
    localparam logic [7:0] SYM_IDL = 8'h7C;

    localparam logic [9:0] SKP_LAST = 10'(SKP_INTERVAL - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SKP,
        ST_DATA,
        ST_ENDS,
        ST_PAD
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [1:0] slot_c;       // lane slot being written this cycle
    logic       word_end;     // slot 3: the word is handed to the lanes on this edge
    logic [7:0] slot0;
    logic [7:0] slot1;
    logic [7:0] slot2;

    logic [7:0] sym;          // symbol written into slot[slot_c] this cycle
    logic       in_rdy;
    logic       abort_nxt;
    logic       skp_enter;    // COM is being written; the pending SKP request is being served

    logic [9:0] skp_cnt;
    logic       skp_pend;

    assign word_end = (slot_c == 2'd3);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // Packet starts and SKP sets only begin at slot 0, so STP/SDP and COM
    // always sit in lane 0. Every other exit back to IDLE happens at slot 3,
    // which keeps IDLE aligned to word boundaries.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (slot_c == 2'd0) begin
                    // A pending SKP wins over a packet start in the same slot.
                    if (skp_pend) begin
                        state_nxt = ST_SKP;
                    end else if (bus.in_valid && bus.in_sop) begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_SKP: begin
                if (word_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bus.in_valid) begin
                    if (bus.in_eop) begin
                        state_nxt = ST_ENDS;
                    end
                end else begin
                    // Underrun: EDB goes in this slot, and PAD fills out the word.
                    state_nxt = word_end ? ST_IDLE : ST_PAD;
                end
            end
            ST_ENDS: begin
                state_nxt = word_end ? ST_IDLE : ST_PAD;
            end
            ST_PAD: begin
                if (word_end) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (symbol for this slot, handshake, abort request)
    // in_ready depends only on state. The sop byte is not consumed in IDLE:
    // it is consumed as the first data byte in the first DATA slot. Any sop
    // seen inside DATA is treated as an ordinary data byte.
    // ------------------------------------------------------------------
    always_comb begin
        sym       = SYM_IDL;
        in_rdy    = 1'b0;
        abort_nxt = 1'b0;
        skp_enter = 1'b0;
        case (state)
            ST_IDLE: begin
                if (slot_c == 2'd0) begin
                    if (skp_pend) begin
                        sym       = SYM_COM;
                        skp_enter = 1'b1;
                    end else if (bus.in_valid && bus.in_sop) begin
                        sym = bus.in_tlp ? SYM_STP : SYM_SDP;
                    end
                end
            end
            ST_SKP: begin
                sym = SYM_SKP;
            end
            ST_DATA: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    sym = bus.in_data;
                end else begin
                    sym       = SYM_EDB;
                    abort_nxt = 1'b1;
                end
            end
            ST_ENDS: begin
                sym = SYM_END;
            end
            ST_PAD: begin
                sym = SYM_PAD;
            end
            default: begin
                sym = SYM_IDL;
            end
        endcase
    end

    assign bus.in_ready = in_rdy;

    // ------------------------------------------------------------------
    // Slot counter and word assembly. Slots 0..2 are held in shadow
    // registers; slot 3 bypasses straight into TL3 on the transfer edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            slot_c <= 2'd0;
            slot0  <= SYM_IDL;
            slot1  <= SYM_IDL;
            slot2  <= SYM_IDL;
        end else begin
            slot_c <= slot_c + 2'd1;
            case (slot_c)
                2'd0:    slot0 <= sym;
                2'd1:    slot1 <= sym;
                2'd2:    slot2 <= sym;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            bus.TL0       <= SYM_IDL;
            bus.TL1       <= SYM_IDL;
            bus.TL2       <= SYM_IDL;
            bus.TL3       <= SYM_IDL;
            bus.out_valid <= 1'b0;
            bus.abort     <= 1'b0;
        end else begin
            bus.out_valid <= word_end;
            bus.abort     <= abort_nxt;
            if (word_end) begin
                bus.TL0 <= slot0;
                bus.TL1 <= slot1;
                bus.TL2 <= slot2;
                bus.TL3 <= sym;
            end
        end
    end

    // ------------------------------------------------------------------
    // SKP scheduling: count transferred words and raise a request every
    // SKP_INTERVAL words. The request stays pending through a packet, and
    // the counter keeps running, until IDLE reaches slot 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            skp_cnt  <= 10'd0;
            skp_pend <= 1'b0;
        end else begin
            if (word_end) begin
                if (skp_cnt == SKP_LAST) begin
                    skp_cnt  <= 10'd0;
                    skp_pend <= 1'b1;
                end else begin
                    skp_cnt <= skp_cnt + 10'd1;
                end
            end
            // Serving happens at slot 0 and raising at slot 3, so the two never collide.
            if (skp_enter) begin
                skp_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stripe_sched.sv
// Self-checking bench for stripe_sched: directed framing cases plus randomized packet traffic,
// compared every cycle against a symbol-queue model of the lane stream.
module tb_stripe_sched;
    localparam int SKP_N = 4;

    localparam logic [7:0] S_COM = 8'hBC;
    localparam logic [7:0] S_PAD = 8'hF7;
    localparam logic [7:0] S_SKP = 8'h1C;
    localparam logic [7:0] S_STP = 8'hFB;
    localparam logic [7:0] S_SDP = 8'h5C;
    localparam logic [7:0] S_END = 8'hFD;
    localparam logic [7:0] S_EDB = 8'hFE;
    localparam logic [7:0] S_IDL = 8'h7C;
    localparam logic [31:0] W_IDL = 32'h7C7C7C7C;
    localparam logic [31:0] W_SKP = 32'hBC1C1C1C;

    logic clk = 1'b0;
    logic reset_L = 1'b0;

    stripe_sched_if bus();

    stripe_sched #(.SKP_INTERVAL(SKP_N)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int abort_cnt = 0;
    logic [31:0] wlog[$];
    logic [7:0]  pd[16];

    logic [31:0] dut_word;
    assign dut_word = {bus.TL0, bus.TL1, bus.TL2, bus.TL3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] getw(input int i);
        if (i < wlog.size()) return wlog[i];
        return 32'hxxxxxxxx;
    endfunction

    // ---------------- reference model ----------------
    // The lane stream is a sequence of symbols, one per cycle, in word-aligned groups of four.
    // Symbols that are already decided (SKP tail, END plus PAD fill) wait in a queue.
    int          m_cyc = 0;
    int          m_words = 0;
    bit          m_in_pkt = 0;
    bit          m_skp_due = 0;
    logic [7:0]  mq[$];
    logic [7:0]  m_cur[4];
    logic [31:0] exp_word = 32'h7C7C7C7C;
    bit          exp_vld = 0;
    bit          exp_abort = 0;

    task automatic model_step();
        int pos;
        logic [7:0] s;
        pos = m_cyc % 4;
        exp_abort = 0;
        if (mq.size() > 0) begin
            s = mq.pop_front();
        end else if (m_in_pkt) begin
            if (bus.in_valid) begin
                s = bus.in_data;
                if (bus.in_eop) begin
                    m_in_pkt = 0;
                    mq.push_back(S_END);
                    repeat (3 - ((pos + 1) % 4)) mq.push_back(S_PAD);
                end
            end else begin
                s = S_EDB;
                exp_abort = 1;
                m_in_pkt = 0;
                repeat (3 - pos) mq.push_back(S_PAD);
            end
        end else if (pos == 0 && m_skp_due) begin
            s = S_COM;
            m_skp_due = 0;
            repeat (3) mq.push_back(S_SKP);
        end else if (pos == 0 && bus.in_valid && bus.in_sop) begin
            s = bus.in_tlp ? S_STP : S_SDP;
            m_in_pkt = 1;
        end else begin
            s = S_IDL;
        end
        m_cur[pos] = s;
        exp_vld = 0;
        if (pos == 3) begin
            exp_word = {m_cur[0], m_cur[1], m_cur[2], m_cur[3]};
            exp_vld = 1;
            m_words++;
            if (m_words % SKP_N == 0) m_skp_due = 1;
        end
        m_cyc++;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_L);
        if (!reset_L) begin
            m_cyc = 0; m_words = 0; m_in_pkt = 0; m_skp_due = 0;
            mq.delete();
            exp_word = W_IDL; exp_vld = 0; exp_abort = 0;
        end else begin
            model_step();
        end
    end

    // ---------------- compare / monitor ----------------
    initial forever begin
        @(negedge clk);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_vld));
        chk("abort", 32'(bus.abort), 32'(exp_abort));
        chk("in_ready", 32'(bus.in_ready), 32'(m_in_pkt && (mq.size() == 0)));
        chk("lane_word", dut_word, exp_word);
        if (reset_L && bus.out_valid) wlog.push_back(dut_word);
        if (bus.abort) abort_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_tlp = 0; bus.in_data = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_L = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        wlog.delete();
        abort_cnt = 0;
        reset_L = 1;
    endtask

    // Holds the current byte until the scheduler takes it; ready is sampled mid-cycle.
    task automatic wait_accept(output bit ok);
        bit r;
        ok = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1;
                return;
            end
        end
    endtask

    // Sends pd[0..len-1]; uat >= 1 drops in_valid for one cycle before byte uat (underrun).
    task automatic send_pkt(input int len, input bit tlp, input int uat);
        bit ok;
        for (int i = 0; i < len; i++) begin
            if (i == uat) begin
                idle_inputs();
                @(posedge clk);
                #1;
                return;
            end
            bus.in_valid = 1;
            bus.in_data  = pd[i];
            bus.in_sop   = (i == 0) || ($urandom_range(0, 7) == 0);
            bus.in_eop   = (i == len - 1);
            bus.in_tlp   = (i == 0) ? tlp : 1'($urandom);
            wait_accept(ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL accept_timeout: byte %0d got no in_ready within 64 cycles, expected acceptance", i);
                break;
            end
        end
        idle_inputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        idle_inputs();

        // Idle link: IDL words, with an SKP word every SKP_N words.
        do_reset();
        repeat (40) @(negedge clk);
        #1;
        chk("idle_w0", getw(0), W_IDL);
        chk("idle_w3", getw(3), W_IDL);
        chk("idle_skp_w4", getw(4), W_SKP);
        chk("idle_w5", getw(5), W_IDL);
        chk("idle_skp_w8", getw(8), W_SKP);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

        // 3-byte TLP
        do_reset();
        pd[0] = 8'hAA; pd[1] = 8'hBB; pd[2] = 8'hCC;
        send_pkt(3, 1, -1);
        repeat (12) @(negedge clk);
        #1;
        chk("tlp_w0", getw(0), 32'hFBAABBCC);
        chk("tlp_w1", getw(1), 32'hFDF7F7F7);
        chk("tlp_w2", getw(2), W_IDL);

        // 2-byte DLLP
        do_reset();
        pd[0] = 8'h11; pd[1] = 8'h22;
        send_pkt(2, 0, -1);
        repeat (12) @(negedge clk);
        #1;
        chk("dllp_w0", getw(0), 32'h5C1122FD);
        chk("dllp_w1", getw(1), W_IDL);

        // Underrun after the first data byte
        do_reset();
        pd[0] = 8'h55; pd[1] = 8'h66; pd[2] = 8'h77;
        send_pkt(3, 1, 1);
        repeat (12) @(negedge clk);
        #1;
        chk("edb_w0", getw(0), 32'hFB55FEF7);
        chk("edb_abort_count", 32'(abort_cnt), 32'd1);
        chk("edb_w1", getw(1), W_IDL);

        // Packet start in the same slot as a pending SKP: SKP goes first
        do_reset();
        n = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (bus.out_valid) n++;
            if (n == 4) break;
        end
        chk("coin_wait_words", 32'(n), 32'd4);
        pd[0] = 8'hDD; pd[1] = 8'hEE;
        send_pkt(2, 1, -1);
        repeat (12) @(negedge clk);
        #1;
        chk("coin_skp_w4", getw(4), W_SKP);
        chk("coin_stp_w5", getw(5), 32'hFBDDEEFD);

        // Asynchronous reset in the middle of a packet
        do_reset();
        bus.in_valid = 1; bus.in_sop = 1; bus.in_tlp = 1; bus.in_eop = 0; bus.in_data = 8'h99;
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        reset_L = 0;
        #1;
        chk("rst_tl_idle", dut_word, W_IDL);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        idle_inputs();
        @(negedge clk);
        wlog.delete();
        abort_cnt = 0;
        reset_L = 1;
        repeat (14) @(negedge clk);
        #1;
        chk("rst_w0", getw(0), W_IDL);
        chk("rst_w1", getw(1), W_IDL);
        chk("rst_no_abort", 32'(abort_cnt), 32'd0);

        // Randomized traffic: lengths, gaps, framing type, stray sop and underruns
        do_reset();
        for (int p = 0; p < 150; p++) begin
            int len;
            int uat;
            int gap;
            gap = $urandom_range(0, 5);
            for (int g = 0; g < gap; g++) begin
                bus.in_valid = 1'($urandom);
                bus.in_sop = 0; bus.in_eop = 0;
                bus.in_data = 8'($urandom);
                @(posedge clk);
                #1;
            end
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) pd[i] = 8'($urandom);
            uat = (len > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, len - 1) : -1;
            send_pkt(len, 1'($urandom), uat);
        end
        idle_inputs();
        repeat (20) @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Run-time bound
    initial begin
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/stripe_sched.md
Name: stripe_sched

Overview:
- Transmit-side lane scheduler for the 4-lane link. It sequences the byte stream from the TX mux onto lanes TL0..TL3, one symbol slot per clk.
- Inserts framing: STP/SDP start, END terminator, EDB on abort, PAD fill, IDL when idle, and periodic COM+SKP ordered sets.
- Sits between the TX mux and the lane serializers. It is the producer for the receive-side byte unstriping logic.

Parameters:
- SKP_INTERVAL, 64, number of output words between SKP ordered-set requests; legal range 2..1023.
- COM/PAD/SKP/STP/SDP/END/EDB/IDL, BC/F7/1C/FB/5C/FD/FE/7C (hex), symbol encodings; must match the unstriping side.

Ports:
- clk  in  1  system clock, rising edge
- reset_L  in  1  asynchronous active-low reset
- in_valid  in  1  upstream byte valid
- in_data  in  8  upstream byte
- in_sop  in  1  first byte of packet; qualified by in_valid
- in_eop  in  1  last byte of packet; qualified by in_valid
- in_tlp  in  1  sampled with sop: 1 = STP (TLP) framing, 0 = SDP (DLLP) framing
- in_ready  out  1  byte accepted this cycle when in_valid && in_ready
- TL0..TL3  out  8 each  lane symbols, registered
- out_valid  out  1  one-cycle strobe: TL0..TL3 hold a new word
- abort  out  1  one-cycle pulse when EDB is inserted

Behaviour:
Reset (async, reset_L=0):
- TL0..TL3=IDL, out_valid=0, abort=0, in_ready=0.
- Slot counter c=0, state=IDLE, skp word counter=0, skp_pend=0.
- Reset mid-packet drops the packet silently; no END or EDB is emitted.

Slot counter and word assembly:
- c is 2 bits, free-running 0..3, wraps 3->0.
- Each cycle, state writes exactly one symbol into shadow slot[c].
- At c==3, slot0..slot3 (slot3 = the symbol written this cycle) transfer to TL0..TL3 on the same edge; out_valid=1 next cycle for 1 cycle.
- Latency: symbol written at slot k appears on TLk 4-k cycles... at the word-transfer edge (c==3).

SKP counter:
- Increments at every c==3.
- When it reaches SKP_INTERVAL-1: set skp_pend, clear counter.
- skp_pend clears when state SKP is entered.

States (evaluated each clk):
- IDLE
  - At c==0 with skp_pend: write COM, go SKP.
  - Else at c==0 with in_valid && in_sop: write STP if in_tlp else SDP; byte is NOT consumed (in_ready=0); go DATA.
  - Otherwise write IDL.
  - SKP has priority over a packet start in the same cycle.
  - in_sop at c!=0 waits for the next c==0.
- SKP: write SKP for slots 1..3; at c==3 return to IDLE. in_ready=0.
- DATA: in_ready=1.
  - in_valid: write in_data. If in_eop, go ENDS.
  - !in_valid (underrun): write EDB, pulse abort, go PAD if c!=3 else IDLE.
  - in_sop asserted inside DATA is ignored (byte treated as data).
- ENDS: write END; in_ready=0. Go IDLE if c==3, else PAD.
- PAD: write PAD until c==3, then IDLE. in_ready=0.

Rules:
- A packet start is always in lane 0, so the receiver can key on TL0.
- in_ready is combinational from state only, never from in_valid.
- A packet may span any number of words.
- END may land in any lane; the remainder of that word is PAD.
- An END landing at c==3 gives a full word with no PAD.
- skp_pend raised during a packet waits until IDLE at c==0; the counter keeps running.
- Single-byte packet (sop && eop): STP, byte, END, PAD.

Test Plan:
- Reset release, no traffic -> out_valid every 4th cycle, TL0..3=7C,7C,7C,7C; in_ready=0.
- 3-byte TLP AA,BB,CC (sop on AA, eop on CC, in_tlp=1) at c==0 -> one word FB,AA,BB,CC, then a word FD,F7,F7,F7.
- 2-byte DLLP 11,22 (in_tlp=0) -> word 5C,11,22,FD; next word IDL.
- in_valid dropped after the first data byte 55 of a TLP -> word FB,55,FE,F7; abort=1 one cycle; following word IDL.
- SKP_INTERVAL=4, idle -> every 4th word is BC,1C,1C,1C. With a packet sop coinciding with skp_pend at c==0 -> the SKP word is sent first, and STP starts lane 0 of the next word.
- reset_L asserted mid-DATA (asynchronous, between edges) -> TL0..3 immediately 7C, state IDLE. After release, the next word is IDL with no END/EDB.
